// File: rtl/qos_fifo_pkg.sv
// Shared constants and width/slice helpers for the per-VC FIFO controllers.
package qos_fifo_pkg;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DEPTH  = 8;

  // Occupancy must hold 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int lsb(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/qos_fifo_ch_ctrl.sv
// Single-channel FIFO controller: request qualification, wrapping addresses,
// occupancy, threshold flags and sticky errors.
module qos_fifo_ch_ctrl
  import qos_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_w(DEPTH),
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [CW-1:0] full_umbral,
  input  logic [CW-1:0] empty_umbral,
  input  logic          err_clr,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow_err,
  output logic          underflow_err
);
  // Explicit wrap so non-power-of-two depths never touch addresses >= DEPTH.
  function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (count >= full_umbral);
    almost_empty = (count <= empty_umbral);
    // A read on a full channel frees the slot the write needs; no empty bypass.
    rd_ok        = reset & rd_en & ~empty;
    wr_ok        = reset & wr_en & (~full | rd_en);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count         <= '0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_ok && !rd_ok)      count <= count + CW'(1);
      else if (rd_ok && !wr_ok) count <= count - CW'(1);
      if (wr_ok) wr_addr <= inc_addr(wr_addr);
      if (rd_ok) rd_addr <= inc_addr(rd_addr);
      // Set has priority over clear.
      overflow_err  <= (wr_en & ~wr_ok) | (overflow_err  & ~err_clr);
      underflow_err <= (rd_en & ~rd_ok) | (underflow_err & ~err_clr);
    end
  end
endmodule

// File: rtl/qos_fifo_ctrl.sv
// Multi-VC FIFO controller: one independent channel controller per VC plus
// an OR-reduced almost_full for arbiter backpressure.
module qos_fifo_ctrl
  import qos_fifo_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = addr_w(DEPTH),
  parameter int CW     = cnt_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    wr_en,
  input  logic [NUM_CH-1:0]    rd_en,
  input  logic [NUM_CH*CW-1:0] full_umbral,
  input  logic [NUM_CH*CW-1:0] empty_umbral,
  input  logic [NUM_CH-1:0]    err_clr,
  output logic [NUM_CH-1:0]    wr_ok,
  output logic [NUM_CH-1:0]    rd_ok,
  output logic [NUM_CH*AW-1:0] wr_addr,
  output logic [NUM_CH*AW-1:0] rd_addr,
  output logic [NUM_CH*CW-1:0] count,
  output logic [NUM_CH-1:0]    full,
  output logic [NUM_CH-1:0]    empty,
  output logic [NUM_CH-1:0]    almost_full,
  output logic [NUM_CH-1:0]    almost_empty,
  output logic [NUM_CH-1:0]    overflow_err,
  output logic [NUM_CH-1:0]    underflow_err,
  output logic                 any_almost_full
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    qos_fifo_ch_ctrl #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en[i]),
      .rd_en        (rd_en[i]),
      .full_umbral  (full_umbral[lsb(i, CW) +: CW]),
      .empty_umbral (empty_umbral[lsb(i, CW) +: CW]),
      .err_clr      (err_clr[i]),
      .wr_ok        (wr_ok[i]),
      .rd_ok        (rd_ok[i]),
      .wr_addr      (wr_addr[lsb(i, AW) +: AW]),
      .rd_addr      (rd_addr[lsb(i, AW) +: AW]),
      .count        (count[lsb(i, CW) +: CW]),
      .full         (full[i]),
      .empty        (empty[i]),
      .almost_full  (almost_full[i]),
      .almost_empty (almost_empty[i]),
      .overflow_err (overflow_err[i]),
      .underflow_err(underflow_err[i])
    );
  end

  assign any_almost_full = |almost_full;
endmodule

// File: tb/tb_qos_fifo_ctrl.sv
// Directed bench: DEPTH=8 instance driven from a vector table, DEPTH=6
// instance for wrap checks on a non-power-of-two depth.
module tb_qos_fifo_ctrl;
  logic clk, reset;

  logic [3:0]  wr8, rd8, clr8, wok8, rok8, full8, empty8, af8, ae8, ovf8, unf8;
  logic [15:0] fu8, eu8, cnt8;
  logic [11:0] wa8, ra8;
  logic        any8;

  logic [3:0]  wr6, rd6, clr6, wok6, rok6, full6, empty6, af6, ae6, ovf6, unf6;
  logic [11:0] fu6, eu6, cnt6, wa6, ra6;
  logic        any6;

  qos_fifo_ctrl #(.NUM_CH(4), .DEPTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .wr_en(wr8), .rd_en(rd8),
    .full_umbral(fu8), .empty_umbral(eu8), .err_clr(clr8),
    .wr_ok(wok8), .rd_ok(rok8), .wr_addr(wa8), .rd_addr(ra8), .count(cnt8),
    .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8),
    .overflow_err(ovf8), .underflow_err(unf8), .any_almost_full(any8));

  qos_fifo_ctrl #(.NUM_CH(4), .DEPTH(6)) u_dut6 (
    .clk(clk), .reset(reset), .wr_en(wr6), .rd_en(rd6),
    .full_umbral(fu6), .empty_umbral(eu6), .err_clr(clr6),
    .wr_ok(wok6), .rd_ok(rok6), .wr_addr(wa6), .rd_addr(ra6), .count(cnt6),
    .full(full6), .empty(empty6), .almost_full(af6), .almost_empty(ae6),
    .overflow_err(ovf6), .underflow_err(unf6), .any_almost_full(any6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // flg = {full, empty, almost_full, almost_empty}
  typedef struct {
    int         ch;
    logic [3:0] wr, rd, clr;
    logic       wok, rok;
    int         cnt, wa, ra;
    logic [3:0] flg;
    logic       ovf, unf;
  } vec_t;

  function automatic vec_t mk(int ch, logic [3:0] wr, logic [3:0] rd, logic [3:0] clr,
                              logic wok, logic rok, int cnt, int wa, int ra,
                              logic [3:0] flg, logic ovf, logic unf);
    vec_t v;
    v.ch = ch; v.wr = wr; v.rd = rd; v.clr = clr; v.wok = wok; v.rok = rok;
    v.cnt = cnt; v.wa = wa; v.ra = ra; v.flg = flg; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  vec_t tv[16];

  initial begin
    int mc, mw, mr;
    logic mwok, mrok;
    tv[0]  = mk(0, 4'h1, 4'h0, 4'h0, 1, 0, 1, 1, 0, 4'b0001, 0, 0);
    tv[1]  = mk(0, 4'h1, 4'h0, 4'h0, 1, 0, 2, 2, 0, 4'b0001, 0, 0);
    tv[2]  = mk(0, 4'h1, 4'h0, 4'h0, 1, 0, 3, 3, 0, 4'b0000, 0, 0);
    tv[3]  = mk(0, 4'h1, 4'h0, 4'h0, 1, 0, 4, 4, 0, 4'b0000, 0, 0);
    tv[4]  = mk(0, 4'h1, 4'h0, 4'h0, 1, 0, 5, 5, 0, 4'b0000, 0, 0);
    tv[5]  = mk(0, 4'h1, 4'h0, 4'h0, 1, 0, 6, 6, 0, 4'b0010, 0, 0);
    tv[6]  = mk(0, 4'h1, 4'h0, 4'h0, 1, 0, 7, 7, 0, 4'b0010, 0, 0);
    tv[7]  = mk(0, 4'h1, 4'h0, 4'h0, 1, 0, 8, 0, 0, 4'b1010, 0, 0);
    tv[8]  = mk(0, 4'h1, 4'h0, 4'h0, 0, 0, 8, 0, 0, 4'b1010, 1, 0);
    tv[9]  = mk(0, 4'h0, 4'h0, 4'h1, 0, 0, 8, 0, 0, 4'b1010, 0, 0);
    tv[10] = mk(0, 4'h1, 4'h1, 4'h0, 1, 1, 8, 1, 1, 4'b1010, 0, 0);
    tv[11] = mk(0, 4'h0, 4'h1, 4'h0, 0, 1, 7, 1, 2, 4'b0010, 0, 0);
    tv[12] = mk(1, 4'h2, 4'h2, 4'h2, 1, 0, 1, 1, 0, 4'b0001, 0, 1);
    tv[13] = mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 0, 4'b0001, 0, 1);
    tv[14] = mk(1, 4'h0, 4'h0, 4'h2, 0, 0, 1, 1, 0, 4'b0001, 0, 0);
    tv[15] = mk(1, 4'h0, 4'h2, 4'h0, 0, 1, 0, 1, 1, 4'b0101, 0, 0);

    reset = 1'b0;
    wr8 = 4'hF; rd8 = '0; clr8 = '0; fu8 = {4{4'd6}}; eu8 = {4{4'd2}};
    wr6 = '0;   rd6 = '0; clr6 = '0; fu6 = {4{3'd5}}; eu6 = {4{3'd1}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ok_forced", int'(wok8), 0);
    chk("rst_count", int'(cnt8), 0);
    chk("rst_wa", int'(wa8), 0);
    chk("rst_ra", int'(ra8), 0);
    chk("rst_empty", int'(empty8), 15);
    chk("rst_almost_empty", int'(ae8), 15);
    chk("rst_full", int'(full8), 0);
    chk("rst_almost_full", int'(af8), 0);
    chk("rst_errs", int'({ovf8, unf8}), 0);
    @(negedge clk);
    reset = 1'b1; wr8 = '0;

    // full_umbral = 0 forces almost_full, seen combinationally.
    #1;
    chk("any_af_idle", int'(any8), 0);
    fu8[15:12] = 4'd0;
    #1;
    chk("ch3_af_thr0", int'(af8[3]), 1);
    chk("any_af_thr0", int'(any8), 1);
    fu8[15:12] = 4'd6;
    #1;
    chk("any_af_restored", int'(any8), 0);

    for (int i = 0; i < 16; i++) begin
      int c;
      c = tv[i].ch;
      @(negedge clk);
      wr8 = tv[i].wr; rd8 = tv[i].rd; clr8 = tv[i].clr;
      #1;
      chk($sformatf("v%0d_wr_ok", i), int'(wok8[c]), int'(tv[i].wok));
      chk($sformatf("v%0d_rd_ok", i), int'(rok8[c]), int'(tv[i].rok));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), int'(cnt8[c*4 +: 4]), tv[i].cnt);
      chk($sformatf("v%0d_wr_addr", i), int'(wa8[c*3 +: 3]), tv[i].wa);
      chk($sformatf("v%0d_rd_addr", i), int'(ra8[c*3 +: 3]), tv[i].ra);
      chk($sformatf("v%0d_flags", i), int'({full8[c], empty8[c], af8[c], ae8[c]}), int'(tv[i].flg));
      chk($sformatf("v%0d_ovf", i), int'(ovf8[c]), int'(tv[i].ovf));
      chk($sformatf("v%0d_unf", i), int'(unf8[c]), int'(tv[i].unf));
    end
    @(negedge clk);
    wr8 = '0; rd8 = '0; clr8 = '0;
    #1;
    chk("ch0_untouched_count", int'(cnt8[3:0]), 7);

    // DEPTH=6: writes every cycle, reads every other cycle on ch2.
    mc = 0; mw = 0; mr = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wr6 = 4'b0100;
      rd6 = (i % 2 == 1) ? 4'b0100 : 4'b0000;
      mrok = rd6[2] && (mc != 0);
      mwok = wr6[2] && ((mc != 6) || rd6[2]);
      #1;
      chk($sformatf("d6_%0d_wr_ok", i), int'(wok6[2]), int'(mwok));
      chk($sformatf("d6_%0d_rd_ok", i), int'(rok6[2]), int'(mrok));
      if (mwok && !mrok) mc++;
      if (mrok && !mwok) mc--;
      if (mwok) mw = (mw == 5) ? 0 : mw + 1;
      if (mrok) mr = (mr == 5) ? 0 : mr + 1;
      @(posedge clk);
      #1;
      chk($sformatf("d6_%0d_count", i), int'(cnt6[6 +: 3]), mc);
      chk($sformatf("d6_%0d_wr_addr", i), int'(wa6[6 +: 3]), mw);
      chk($sformatf("d6_%0d_rd_addr", i), int'(ra6[6 +: 3]), mr);
      chk($sformatf("d6_%0d_wa_range", i), int'(wa6[6 +: 3] < 3'd6), 1);
    end
    chk("d6_overflow", int'(ovf6[2]), 1);
    chk("d6_full", int'(full6[2]), 1);

    // Reset mid-stream on both instances.
    @(negedge clk);
    reset = 1'b0; wr8 = 4'h1; wr6 = 4'b0100; rd6 = '0;
    #1;
    chk("midrst_wr_ok8", int'(wok8), 0);
    chk("midrst_wr_ok6", int'(wok6), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; wr8 = '0; wr6 = '0;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("midrst8_ch%0d", c),
          int'({cnt8[c*4 +: 4], wa8[c*3 +: 3], ra8[c*3 +: 3], ovf8[c], unf8[c], empty8[c]}), 1);
      chk($sformatf("midrst6_ch%0d", c),
          int'({cnt6[c*3 +: 3], wa6[c*3 +: 3], ra6[c*3 +: 3], ovf6[c], unf6[c], empty6[c]}), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qos_fifo_ctrl.md
Name: qos_fifo_ctrl

Overview:
Parametrised multi-channel FIFO controller for the QoS PCIe datapath, one independent controller per virtual channel. It qualifies write and read requests and generates wrapping read/write addresses for an external RAM. It tracks occupancy and decodes full, empty, almost_full and almost_empty against per-channel programmable thresholds. It also records sticky overflow and underflow errors. It sits between the VC demux/arbiter and the per-VC data RAMs.

Parameters:
NUM_CH, 4, number of independent channels
DEPTH, 8, entries per channel FIFO (any value >= 2; power of two not required)
AW, $clog2(DEPTH), address width
CW, $clog2(DEPTH+1), occupancy counter width (holds 0..DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
wr_en  in  NUM_CH  per-channel write request
rd_en  in  NUM_CH  per-channel read request
full_umbral  in  NUM_CH*CW  almost_full threshold; channel i at bits [i*CW +: CW]
empty_umbral  in  NUM_CH*CW  almost_empty threshold, same packing
err_clr  in  NUM_CH  clears the sticky error bits of that channel
wr_ok  out  NUM_CH  write accepted this cycle (RAM write enable)
rd_ok  out  NUM_CH  read accepted this cycle (RAM read enable)
wr_addr  out  NUM_CH*AW  current write address
rd_addr  out  NUM_CH*AW  current read address
count  out  NUM_CH*CW  occupancy
full, empty, almost_full, almost_empty  out  NUM_CH each  status flags
overflow_err, underflow_err  out  NUM_CH each  sticky error flags
any_almost_full  out  1  OR of almost_full, used by the arbiter for backpressure

Behaviour:
- Reset (reset==0 at posedge clk): count=0, wr_addr=rd_addr=0 and both error bits=0 on every channel. Consequence: empty=1, almost_empty=1, full=0, almost_full=0.
- Reset mid-operation discards all contents. wr_ok and rd_ok are forced to 0 while reset==0.
- rd_ok = rd_en & ~empty.
- wr_ok = wr_en & (~full | rd_en). On a full channel, a simultaneous read frees a slot, so the write is accepted.
- Counter update per posedge:
  - wr_ok only: +1
  - rd_ok only: -1
  - both or neither: unchanged
- Because of the qualification above, count never leaves 0..DEPTH.
- Empty with wr_en & rd_en: the read is rejected (no bypass), the write is accepted, count goes 0->1 and underflow_err is set.
- Address update:
  - wr_addr advances by 1 on wr_ok; rd_addr advances by 1 on rd_ok.
  - Both wrap from DEPTH-1 to 0 explicitly, not by natural overflow.
  - Addresses are registered; rd_addr is valid for the RAM in the same cycle rd_ok is asserted.
- Flags are combinational decodes of the registered count, so they reflect an operation one cycle after its clock edge:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count >= full_umbral)
  - almost_empty = (count <= empty_umbral)
- The flags are independent. Overlapping thresholds may assert almost_full and almost_empty together, and full implies almost_full whenever full_umbral <= DEPTH.
- Threshold changes take effect combinationally in the same cycle. full_umbral=0 forces almost_full=1.
- Errors:
  - overflow_err sets on wr_en & ~wr_ok; underflow_err sets on rd_en & ~rd_ok.
  - Both are sticky until err_clr.
  - If set and clear occur in the same cycle, set wins.
- Rejected operations change neither count nor addresses.
- Channels are fully independent; no cross-channel interaction except any_almost_full.

Decomposition:
- Package qos_fifo_pkg: default DEPTH/NUM_CH constants, a width helper for CW/AW, and slice-index helper constants.
- Sub-module qos_fifo_ch_ctrl: single-channel counter, addresses, flags and errors.
- Top qos_fifo_ctrl: generate loop of NUM_CH instances plus the any_almost_full OR-reduce.

Test Plan:
- Reset then idle; ch0 thresholds full_umbral=6, empty_umbral=2 -> count=0, empty=1, almost_empty=1, full=0, all addr=0, errors=0.
- 8 consecutive writes on ch0 (DEPTH=8) -> count 1..8; almost_empty drops at count=3; almost_full rises at count=6; full=1 at count=8; wr_addr wraps back to 0.
- 9th write alone on full ch0 -> wr_ok=0, count stays 8, overflow_err=1. A later err_clr pulse -> overflow_err=0.
- Full ch0 with wr_en=rd_en=1 -> wr_ok=rd_ok=1, count stays 8, wr_addr and rd_addr both advance.
- Empty ch1 with wr_en=rd_en=1 -> wr_ok=1, rd_ok=0, count=1, underflow_err=1; err_clr asserted in the same cycle still leaves underflow_err=1.
- DEPTH=6 build, 14 writes interleaved with reads on ch2 -> addresses wrap 5->0 and never reach 6 or 7. Reset pulsed mid-stream -> next cycle count=0, empty=1, addresses 0; other channels reset too.
